// File: rtl/csi2_video_crop_pkg.sv
// ---------------------------------------------------------------------------
// csi2_video_crop_pkg
// Shared defaults for the CSI-2 pixel-stream crop block.
//   TDATA_WIDTH_DEF : default pixel beat width in bits
//   CNT_WIDTH_DEF   : default width of the x/y counters and window inputs
//   byte_lanes()    : number of tstrb/tkeep lanes for a given tdata width
// ---------------------------------------------------------------------------
package csi2_video_crop_pkg;

    localparam int TDATA_WIDTH_DEF = 16;
    localparam int CNT_WIDTH_DEF   = 13;

    // Number of byte lanes covering a beat of the given width.
    function automatic int byte_lanes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/axi4_stream_out_reg.sv
// ---------------------------------------------------------------------------
// axi4_stream_out_reg
// Single-stage AXI4-Stream output register with full throughput.
//   clk         : clock
//   srst        : synchronous active-high reset, drops any held beat
//   in_valid    : load request for in_payload
//   in_payload  : beat to be registered
//   in_ready    : register can take a beat this cycle
//   out_valid   : registered beat present
//   out_payload : registered beat, stable while out_valid && !out_ready
//   out_ready   : downstream accepts the registered beat
// ---------------------------------------------------------------------------
module axi4_stream_out_reg #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          in_valid,
    input  logic [PW-1:0] in_payload,
    output logic          in_ready,
    output logic          out_valid,
    output logic [PW-1:0] out_payload,
    input  logic          out_ready
);

    logic          valid_r;
    logic [PW-1:0] payload_r;

    // Free when empty or when the held beat leaves this cycle.
    assign in_ready    = !valid_r || out_ready;
    assign out_valid   = valid_r;
    assign out_payload = payload_r;

    // Beat holding register: reload on accept, empty after handshake.
    always_ff @(posedge clk) begin
        if (srst) begin
            valid_r   <= 1'b0;
            payload_r <= '0;
        end else if (in_valid && in_ready) begin
            valid_r   <= 1'b1;
            payload_r <= in_payload;
        end else if (out_ready) begin
            valid_r   <= 1'b0;
        end
    end

endmodule

// File: rtl/csi2_video_crop.sv
// ---------------------------------------------------------------------------
// csi2_video_crop
// Crops a rectangular window out of the pixel stream from the CSI-2 receiver.
// Window offset/size are latched at start-of-frame; out-of-window pixels are
// dropped, in-window pixels are re-framed (new SOF/EOL) and sent downstream.
//   clk_i, srst_i          : pixel clock, synchronous active-high reset
//   crop_x_i / crop_y_i    : window first column / first row (sampled at SOF)
//   crop_w_i / crop_h_i    : window width / height (sampled at SOF)
//   line_short_o           : pulse, input EOL before window right edge in window rows
//   frame_done_o           : pulse, last window beat accepted downstream
//   video_i_*              : input stream, tuser=SOF, tlast=EOL, one pixel/beat
//   video_o_*              : cropped output stream, same framing
// ---------------------------------------------------------------------------
module csi2_video_crop
    import csi2_video_crop_pkg::*;
#(
    parameter int TDATA_WIDTH = TDATA_WIDTH_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    localparam int KW         = byte_lanes(TDATA_WIDTH)
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic [CNT_WIDTH-1:0]   crop_x_i,
    input  logic [CNT_WIDTH-1:0]   crop_y_i,
    input  logic [CNT_WIDTH-1:0]   crop_w_i,
    input  logic [CNT_WIDTH-1:0]   crop_h_i,
    output logic                   line_short_o,
    output logic                   frame_done_o,
    input  logic [TDATA_WIDTH-1:0] video_i_tdata,
    input  logic [KW-1:0]          video_i_tstrb,
    input  logic [KW-1:0]          video_i_tkeep,
    input  logic                   video_i_tuser,
    input  logic                   video_i_tlast,
    input  logic                   video_i_tvalid,
    output logic                   video_i_tready,
    output logic [TDATA_WIDTH-1:0] video_o_tdata,
    output logic [KW-1:0]          video_o_tstrb,
    output logic [KW-1:0]          video_o_tkeep,
    output logic                   video_o_tuser,
    output logic                   video_o_tlast,
    output logic                   video_o_tvalid,
    input  logic                   video_o_tready
);

    localparam int PW = TDATA_WIDTH + 2 * KW + 3;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH:0]   EXT_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] x_cnt_r, y_cnt_r;
    logic [CNT_WIDTH-1:0] x0_r, y0_r, w_r, h_r;
    logic                 sof_seen_r;
    logic                 line_short_r;
    logic                 frame_done_r;

    logic                 accept_s, sof_s, sof_seen_s;
    logic [CNT_WIDTH-1:0] x_s, y_s, x0_s, y0_s, w_s, h_s;
    logic [CNT_WIDTH-1:0] x_inc_s, y_inc_s;
    logic [CNT_WIDTH:0]   x_e_s, y_e_s, x0_e_s, y0_e_s, w_e_s, h_e_s;
    logic [CNT_WIDTH:0]   dx_s, dy_s;
    logic                 col_in_s, row_in_s, inside_s;
    logic                 last_col_s, last_row_s, short_s;
    logic                 out_tuser_s, out_tlast_s, load_s;
    logic [PW-1:0]        in_payload_s, out_payload_s;
    logic                 out_last_row_s;

    assign accept_s   = video_i_tvalid && video_i_tready;
    assign sof_s      = video_i_tuser;
    assign sof_seen_s = sof_seen_r || sof_s;

    // A SOF beat is position (0,0) and uses the window inputs directly,
    // since the shadows only take them at the end of this cycle.
    assign x_s  = sof_s ? '0 : x_cnt_r;
    assign y_s  = sof_s ? '0 : y_cnt_r;
    assign x0_s = sof_s ? crop_x_i : x0_r;
    assign y0_s = sof_s ? crop_y_i : y0_r;
    assign w_s  = sof_s ? crop_w_i : w_r;
    assign h_s  = sof_s ? crop_h_i : h_r;

    // One extra bit so offset+size never overflows.
    assign x_e_s  = {1'b0, x_s};
    assign y_e_s  = {1'b0, y_s};
    assign x0_e_s = {1'b0, x0_s};
    assign y0_e_s = {1'b0, y0_s};
    assign w_e_s  = {1'b0, w_s};
    assign h_e_s  = {1'b0, h_s};
    assign dx_s   = x_e_s - x0_e_s;
    assign dy_s   = y_e_s - y0_e_s;

    assign col_in_s   = (x_e_s >= x0_e_s) && (dx_s < w_e_s);
    assign row_in_s   = (y_e_s >= y0_e_s) && (dy_s < h_e_s);
    assign inside_s   = sof_seen_s && col_in_s && row_in_s;
    // "+1 ==" form avoids an underflowing "W-1" when W is zero.
    assign last_col_s = (dx_s + EXT_ONE) == w_e_s;
    assign last_row_s = (dy_s + EXT_ONE) == h_e_s;
    // x < X0+W-1 rewritten as x+1 < X0+W, also covers x < X0.
    assign short_s    = (x_e_s + EXT_ONE) < (x0_e_s + w_e_s);

    assign out_tuser_s = (x_s == x0_s) && (y_s == y0_s);
    assign out_tlast_s = last_col_s || video_i_tlast;
    assign load_s      = accept_s && inside_s;

    // Saturating increments: counters stick at all-ones on oversized frames.
    assign x_inc_s = (x_s == {CNT_WIDTH{1'b1}}) ? x_s : x_s + CNT_ONE;
    assign y_inc_s = (y_s == {CNT_WIDTH{1'b1}}) ? y_s : y_s + CNT_ONE;

    // The last-row flag travels with the beat so frame_done_o can be tied
    // to the downstream handshake rather than to input acceptance.
    assign in_payload_s = {last_row_s, video_i_tkeep, video_i_tstrb,
                           out_tuser_s, out_tlast_s, video_i_tdata};

    axi4_stream_out_reg #(
        .PW (PW)
    ) u_out_reg (
        .clk         (clk_i),
        .srst        (srst_i),
        .in_valid    (load_s),
        .in_payload  (in_payload_s),
        .in_ready    (video_i_tready),
        .out_valid   (video_o_tvalid),
        .out_payload (out_payload_s),
        .out_ready   (video_o_tready)
    );

    assign {out_last_row_s, video_o_tkeep, video_o_tstrb,
            video_o_tuser, video_o_tlast, video_o_tdata} = out_payload_s;

    assign line_short_o = line_short_r;
    assign frame_done_o = frame_done_r;

    // Position counters, window shadows and status pulses.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            x_cnt_r      <= '0;
            y_cnt_r      <= '0;
            x0_r         <= '0;
            y0_r         <= '0;
            w_r          <= '0;
            h_r          <= '0;
            sof_seen_r   <= 1'b0;
            line_short_r <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (accept_s) begin
                if (video_i_tlast) begin
                    x_cnt_r <= '0;
                    y_cnt_r <= y_inc_s;
                end else begin
                    x_cnt_r <= x_inc_s;
                    y_cnt_r <= y_s;
                end
                if (sof_s) begin
                    x0_r       <= crop_x_i;
                    y0_r       <= crop_y_i;
                    w_r        <= crop_w_i;
                    h_r        <= crop_h_i;
                    sof_seen_r <= 1'b1;
                end
            end
            line_short_r <= accept_s && video_i_tlast && sof_seen_s && row_in_s && short_s;
            frame_done_r <= video_o_tvalid && video_o_tready && video_o_tlast && out_last_row_s;
        end
    end

endmodule
